// File: rtl/segment_scheduler_pkg.sv
// Shared constants for the segment scheduler: quadrant window geometry,
// segment column bases and the scheduler state encoding.
package segment_scheduler_pkg;

  localparam int NUM_SEG  = 6;
  localparam int NUM_QUAD = 4;
  localparam int NUM_IDX  = NUM_SEG * NUM_QUAD;

  localparam logic [9:0] ROW_TOP = 10'd150;
  localparam logic [9:0] ROW_MID = 10'd225;
  localparam logic [9:0] ROW_BOT = 10'd300;
  localparam logic [9:0] HALF_W  = 10'd37;
  localparam logic [9:0] QUAD_W  = 10'd75;

  // Capture ends on the first pixel of the line just below the bottom window row
  localparam logic [9:0] EVAL_V    = 10'd301;
  localparam logic [4:0] EVAL_LAST = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CLEAR,
    S_CAPTURE,
    S_EVAL,
    S_DONE
  } state_t;

  function automatic logic [9:0] seg_base(input logic [2:0] seg);
    case (seg)
      3'd0:    seg_base = 10'd50;
      3'd1:    seg_base = 10'd140;
      3'd2:    seg_base = 10'd230;
      3'd3:    seg_base = 10'd335;
      3'd4:    seg_base = 10'd425;
      3'd5:    seg_base = 10'd515;
      default: seg_base = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_window_decode.sv
// Maps a VGA pixel position to the quadrant window it falls in, if any.
// Purely combinational; idx = seg*4 + quad with quad = {bottom_row, right_half}.
module seg_window_decode
  import segment_scheduler_pkg::*;
(
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  output logic       hit,
  output logic [4:0] idx
);

  logic       top_row;
  logic       bot_row;
  logic [9:0] base;

  always_comb begin
    hit     = 1'b0;
    idx     = 5'd0;
    base    = 10'd0;
    top_row = (vcnt > ROW_TOP) && (vcnt <= ROW_MID);
    bot_row = (vcnt > ROW_MID) && (vcnt <= ROW_BOT);
    for (int s = 0; s < NUM_SEG; s++) begin
      base = seg_base(3'(s));
      if (top_row || bot_row) begin
        if ((hcnt > base) && (hcnt <= base + HALF_W)) begin
          hit = 1'b1;
          idx = {3'(s), bot_row, 1'b0};
        end else if ((hcnt > base + HALF_W) && (hcnt <= base + QUAD_W)) begin
          hit = 1'b1;
          idx = {3'(s), bot_row, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/segment_scheduler.sv
// Frame capture scheduler: waits for start of frame, clears and steers the
// quadrant accumulators, then reads them back and thresholds into seg_codes.
module segment_scheduler
  import segment_scheduler_pkg::*;
#(
  parameter int               CNT_W  = 14,
  parameter logic [CNT_W-1:0] THRESH = 14'd75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       hcnt,
  input  logic [9:0]       vcnt,
  input  logic             start,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [4:0]       acc_sel,
  output logic [4:0]       rd_idx,
  input  logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [23:0]      seg_codes
);

  state_t      state;
  state_t      next_state;
  logic [4:0]  eval_cnt;
  logic [23:0] code_reg;
  logic [23:0] code_next;
  logic        win_hit;
  logic [4:0]  win_idx;

  seg_window_decode u_decode (
    .hcnt (hcnt),
    .vcnt (vcnt),
    .hit  (win_hit),
    .idx  (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = S_WAIT_SOF;
      S_WAIT_SOF: if (hcnt == 10'd0 && vcnt == 10'd0) next_state = S_CLEAR;
      S_CLEAR:    next_state = S_CAPTURE;
      S_CAPTURE:  if (hcnt == 10'd0 && vcnt == EVAL_V) next_state = S_EVAL;
      S_EVAL:     if (eval_cnt == EVAL_LAST) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    acc_clr = (state == S_CLEAR);
    acc_en  = (state == S_CAPTURE) && win_hit;
    acc_sel = acc_en ? win_idx : 5'd0;
    rd_idx  = ((state == S_EVAL) && (eval_cnt < EVAL_LAST)) ? eval_cnt : 5'd0;
  end

  // rd_data lags rd_idx by one cycle, so eval cycle k resolves index k-1
  always_comb begin
    code_next = code_reg;
    if (state == S_EVAL && eval_cnt != 5'd0)
      code_next[eval_cnt - 5'd1] = (rd_data >= THRESH);
  end

  // seg_codes loads together with the final bit so done never sees a partial code
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_cnt  <= 5'd0;
      code_reg  <= 24'd0;
      seg_codes <= 24'd0;
    end else if (state == S_EVAL) begin
      eval_cnt <= eval_cnt + 5'd1;
      code_reg <= code_next;
      if (eval_cnt == EVAL_LAST) seg_codes <= code_next;
    end else begin
      eval_cnt <= 5'd0;
      code_reg <= 24'd0;
    end
  end

endmodule

// File: doc/segment_scheduler.md
SEGMENT_SCHEDULER -- requirements
Module: segment_scheduler

Interface
REQ-001 Parameter THRESH, default 14'd75: quadrant count at or above which the quadrant bit is set.
REQ-002 Parameter CNT_W, default 14: width of quadrant accumulator counts.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 hcnt  in  10  VGA horizontal pixel counter.
REQ-006 vcnt  in  10  VGA vertical line counter.
REQ-007 start  in  1  request one frame capture plus evaluation; 1-cycle pulse.
REQ-008 acc_clr  out  1  clear all 24 quadrant accumulators.
REQ-009 acc_en  out  1  current pixel falls in a quadrant window; accumulate.
REQ-010 acc_sel  out  5  quadrant index 0..23 for the current pixel (seg*4 + quad).
REQ-011 rd_idx  out  5  quadrant index being read during evaluation.
REQ-012 rd_data  in  CNT_W  accumulator value for rd_idx, valid one cycle after rd_idx.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  1-cycle pulse; seg_codes valid.
REQ-015 seg_codes  out  24  six 4-bit codes, segment s in bits [4s+3:4s], quad q in bit q.

Function
REQ-016 States SHALL be IDLE, WAIT_SOF, CLEAR, CAPTURE, EVAL, DONE.
REQ-017 IDLE: start=1 -> WAIT_SOF, busy=1 next cycle; start while busy=1 SHALL be ignored.
REQ-018 WAIT_SOF: hcnt==0 and vcnt==0 -> CLEAR.
REQ-019 CLEAR: acc_clr=1 for exactly one cycle, then CAPTURE.
REQ-020 CAPTURE: acc_en=1 iff pixel is inside a window (REQ-021/022); acc_sel valid whenever acc_en=1, else 0.
REQ-021 Rows: quads 0,1 for 150<vcnt<=225; quads 2,3 for 225<vcnt<=300.
REQ-022 Columns: segment s, base Xs from {50,140,230,335,425,515}; left quad Xs<hcnt<=Xs+37, right quad Xs+37<hcnt<=Xs+75.
REQ-023 acc_en/acc_sel SHALL be combinational from hcnt/vcnt and state (zero-latency with pixel).
REQ-024 CAPTURE -> EVAL when vcnt==301 and hcnt==0.
REQ-025 EVAL: rd_idx steps 0..23, one per cycle; compare of rd_data for index i occurs the cycle after rd_idx=i.
REQ-026 Bit i of the internal code register SHALL be set iff rd_data >= THRESH (unsigned, CNT_W bits); register cleared on entering EVAL.
REQ-027 EVAL lasts 25 cycles (24 reads + 1 latency), then DONE.
REQ-028 DONE: seg_codes updated from internal register, done=1 one cycle, busy=0 next cycle, -> IDLE.
REQ-029 seg_codes SHALL hold the last completed result until the next DONE; never show partial results.
REQ-030 rd_idx SHALL be 0 outside EVAL; acc_clr 0 outside CLEAR.
REQ-031 start coincident with done SHALL be ignored (busy still high).

Reset
REQ-032 rst SHALL force IDLE; busy, done, acc_clr, acc_en, acc_sel, rd_idx, seg_codes = 0.
REQ-033 rst mid-CAPTURE or mid-EVAL SHALL abort without a done pulse; seg_codes = 0.

Structure
REQ-034 Shared package holds segment bases, window row/column bounds, NUM_SEG=6, NUM_QUAD=4, state encoding.
REQ-035 Sub-module seg_window_decode (hcnt,vcnt -> hit, idx) SHALL be separate and combinational; scheduler FSM instantiates it.

Verification
REQ-036 start, run full frame with model counts all 80 -> done once, seg_codes=24'hFFFFFF.
REQ-037 Counts: quad i = 100 if i even else 10 -> seg_codes=24'h555555.
REQ-038 hcnt=88,vcnt=200 in CAPTURE -> acc_en=1, acc_sel=1; hcnt=130,vcnt=200 -> acc_en=0; vcnt=300/301 boundary checked.
REQ-039 rd_data = THRESH-1 at idx 5, THRESH at idx 6 -> bit5=0, bit6=1.
REQ-040 rst asserted at EVAL rd_idx=10 -> IDLE next cycle, no done, seg_codes=0, busy=0.
REQ-041 Second start while busy -> no extra frame; exactly one done; acc_clr pulses once per accepted start.
